math_operand_loader: RTL

MATH_OPERAND_LOADER -- requirements
Module: math_operand_loader

---
 rtl/math_operand_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/math_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : math_operand_loader
// Description : Collects serial A, B, C words into a registered operand triple
//               for unit_math, with ready/valid on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module math_operand_loader #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       triple_count
);

    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_s_q, a_s_d;
    logic [WIDTH-1:0] b_s_q, b_s_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             w_in_hs;
    logic             w_out_hs;

    // Only the C word needs the output slot, so A and B are taken regardless.
    assign in_ready = ~rst & ~flush &
                      ((state_q != S_C) | ~out_valid_q | out_ready);
    assign w_in_hs  = in_valid & in_ready;
    assign w_out_hs = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        a_s_d       = a_s_q;
        b_s_d       = b_s_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (w_out_hs) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + 8'd1;
        end

        if (flush) begin
            state_d = S_A;
            a_s_d   = '0;
            b_s_d   = '0;
        end else if (w_in_hs) begin
            case (state_q)
                S_A: begin
                    a_s_d   = in_data;
                    state_d = S_B;
                end
                S_B: begin
                    b_s_d   = in_data;
                    state_d = S_C;
                end
                S_C: begin
                    // Overrides a same-cycle drain so back-to-back triples have no bubble.
                    out_a_d     = a_s_q;
                    out_b_d     = b_s_q;
                    out_c_d     = in_data;
                    out_valid_d = 1'b1;
                    state_d     = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            a_s_q       <= '0;
            b_s_q       <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            a_s_q       <= a_s_d;
            b_s_q       <= b_s_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign out_c        = out_c_q;
    assign out_valid    = out_valid_q;
    assign triple_count = cnt_q;

endmodule
`default_nettype wire
